// File: rtl/i2c_master_engine_pkg.sv
// Shared types and constants for the I2C master engine.
package i2c_pkg;

    localparam int I2C_PRESCALE_WIDTH   = 16;
    localparam int I2C_DATA_WIDTH       = 8;
    localparam int I2C_QUARTERS_PER_BIT = 4;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       rw;
        logic [7:0] data;
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        RXWAIT,
        HOLD,
        STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_master_engine_if.sv
// Command/RX handshake and open-drain bus lines of the I2C master engine.
interface i2c_master_engine_if;
    import i2c_pkg::*;

    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    i2c_cmd_t                  cmd_i;
    logic                      rx_valid_o;
    logic                      rx_ready_i;
    logic [I2C_DATA_WIDTH-1:0] rx_data_o;
    logic                      scl_i;
    logic                      sda_i;
    logic                      scl_oe_o;
    logic                      sda_oe_o;

    modport master (
        input  cmd_valid_i, cmd_i, rx_ready_i, scl_i, sda_i,
        output cmd_ready_o, rx_valid_o, rx_data_o, scl_oe_o, sda_oe_o
    );

    modport slave (
        output cmd_valid_i, cmd_i, rx_ready_i, scl_i, sda_i,
        input  cmd_ready_o, rx_valid_o, rx_data_o, scl_oe_o, sda_oe_o
    );

endinterface

// File: rtl/i2c_master_engine_quarter_tick.sv
// Quarter-bit timebase: prescale down-counter with tick, quarter index and freeze.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int PRESCALE_WIDTH = I2C_PRESCALE_WIDTH,
    localparam int QW            = $clog2(I2C_QUARTERS_PER_BIT)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      srst_i,
    input  logic                      load_i,
    input  logic                      run_i,
    input  logic                      freeze_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      tick_o,
    output logic [QW-1:0]             quarter_o
);

    logic [PRESCALE_WIDTH-1:0] presc_r;
    logic [PRESCALE_WIDTH-1:0] cnt_r;
    logic [QW-1:0]             quarter_r;
    logic                      zero_s;

    assign zero_s    = (cnt_r == {PRESCALE_WIDTH{1'b0}});
    assign tick_o    = run_i && !freeze_i && zero_s;
    assign quarter_o = quarter_r;

    // Load restarts at quarter 0 and latches prescale for the whole transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_r   <= {PRESCALE_WIDTH{1'b0}};
            cnt_r     <= {PRESCALE_WIDTH{1'b0}};
            quarter_r <= {QW{1'b0}};
        end else if (srst_i) begin
            presc_r   <= {PRESCALE_WIDTH{1'b0}};
            cnt_r     <= {PRESCALE_WIDTH{1'b0}};
            quarter_r <= {QW{1'b0}};
        end else if (load_i) begin
            presc_r   <= prescale_i;
            cnt_r     <= prescale_i;
            quarter_r <= {QW{1'b0}};
        end else if (run_i && !freeze_i) begin
            if (zero_s) begin
                cnt_r     <= presc_r;
                quarter_r <= quarter_r + QW'(1);
            end else begin
                cnt_r     <= cnt_r - PRESCALE_WIDTH'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/i2c_master_engine.sv
// Bit-level I2C master: START/rSTART, 8-bit data, ACK, STOP sequencing.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL during each q1.
module i2c_master_engine
    import i2c_pkg::*;
#(
    parameter int PRESCALE_WIDTH = I2C_PRESCALE_WIDTH,
    parameter int DATA_WIDTH     = I2C_DATA_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      core_rst_i,
    input  logic                      core_en_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      busy_o,
    output logic                      rx_ack_o,
    i2c_master_engine_if.master       bus
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    i2c_state_e            state_r;
    logic                  scl_oe_r;
    logic                  sda_oe_r;
    logic                  busy_r;
    logic                  rx_ack_r;
    logic                  rx_valid_r;
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [2:0]            bit_cnt_r;
    logic                  rw_r;
    logic                  stop_r;

    logic       cmd_ready_s;
    logic       accept_s;
    logic       rx_take_s;
    logic       run_s;
    logic       freeze_s;
    logic       tick_s;
    logic [1:0] quarter_s;

    assign cmd_ready_s = !rst_i && !core_rst_i &&
                         (((state_r == IDLE) && core_en_i) || (state_r == HOLD));
    assign accept_s    = bus.cmd_valid_i && cmd_ready_s;
    assign rx_take_s   = (state_r == RXWAIT) && bus.rx_ready_i;
    assign run_s       = (state_r == START) || (state_r == BIT) ||
                         (state_r == ACK)   || (state_r == STOP);

`ifdef I2C_CLK_STRETCH_EN
    assign freeze_s = run_s && (quarter_s == 2'd1) && !bus.scl_i;
`else
    assign freeze_s = 1'b0;
`endif

    i2c_quarter_tick #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_tick (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .srst_i     (core_rst_i),
        .load_i     (accept_s || rx_take_s),
        .run_i      (run_s),
        .freeze_i   (freeze_s),
        .prescale_i (prescale_i),
        .tick_o     (tick_s),
        .quarter_o  (quarter_s)
    );

    assign bus.cmd_ready_o = cmd_ready_s;
    assign bus.rx_valid_o  = rx_valid_r;
    assign bus.rx_data_o   = rx_data_r;
    assign bus.scl_oe_o    = scl_oe_r;
    assign bus.sda_oe_o    = sda_oe_r;
    assign busy_o          = busy_r;
    assign rx_ack_o        = rx_ack_r;

    // Sequencer: each tick ends a quarter and sets the line levels for the next one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            scl_oe_r   <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            rx_ack_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= {DATA_WIDTH{1'b0}};
            shift_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= 3'd0;
            rw_r       <= 1'b0;
            stop_r     <= 1'b0;
        end else if (core_rst_i) begin
            state_r    <= IDLE;
            scl_oe_r   <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            rx_ack_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= {DATA_WIDTH{1'b0}};
            shift_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= 3'd0;
            rw_r       <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        busy_r   <= 1'b1;
                        rw_r     <= bus.cmd_i.rw;
                        stop_r   <= bus.cmd_i.stop;
                        shift_r  <= bus.cmd_i.data;
                        scl_oe_r <= 1'b0;
                        sda_oe_r <= 1'b0;
                        state_r  <= START;
                    end
                end
                HOLD: begin
                    if (accept_s) begin
                        rw_r    <= bus.cmd_i.rw;
                        stop_r  <= bus.cmd_i.stop;
                        shift_r <= bus.cmd_i.data;
                        if (bus.cmd_i.start) begin
                            sda_oe_r <= 1'b0;
                            state_r  <= START;
                        end else begin
                            bit_cnt_r <= 3'd0;
                            sda_oe_r  <= !bus.cmd_i.rw && !bus.cmd_i.data[DATA_WIDTH-1];
                            state_r   <= BIT;
                        end
                    end
                end
                START: begin
                    if (tick_s) begin
                        case (quarter_s)
                            2'd0: scl_oe_r <= 1'b0;
                            2'd1: sda_oe_r <= 1'b1;
                            2'd2: scl_oe_r <= 1'b1;
                            2'd3: begin
                                bit_cnt_r <= 3'd0;
                                sda_oe_r  <= !rw_r && !shift_r[DATA_WIDTH-1];
                                state_r   <= BIT;
                            end
                            default: state_r <= IDLE;
                        endcase
                    end
                end
                BIT: begin
                    if (tick_s) begin
                        case (quarter_s)
                            2'd0: scl_oe_r <= 1'b0;
                            2'd1: scl_oe_r <= 1'b0;
                            2'd2: begin
                                shift_r  <= {shift_r[DATA_WIDTH-2:0], bus.sda_i};
                                scl_oe_r <= 1'b1;
                            end
                            2'd3: begin
                                if (bit_cnt_r == LAST_BIT) begin
                                    if (rw_r) begin
                                        rx_valid_r <= 1'b1;
                                        rx_data_r  <= shift_r;
                                        state_r    <= RXWAIT;
                                    end else begin
                                        sda_oe_r <= 1'b0;
                                        state_r  <= ACK;
                                    end
                                end else begin
                                    bit_cnt_r <= bit_cnt_r + 3'd1;
                                    sda_oe_r  <= !rw_r && !shift_r[DATA_WIDTH-1];
                                end
                            end
                            default: state_r <= IDLE;
                        endcase
                    end
                end
                RXWAIT: begin
                    // Master NACKs the final byte of a read so the slave lets go of SDA.
                    if (bus.rx_ready_i) begin
                        rx_valid_r <= 1'b0;
                        sda_oe_r   <= !stop_r;
                        state_r    <= ACK;
                    end
                end
                ACK: begin
                    if (tick_s) begin
                        case (quarter_s)
                            2'd0: scl_oe_r <= 1'b0;
                            2'd1: scl_oe_r <= 1'b0;
                            2'd2: begin
                                if (!rw_r) begin
                                    rx_ack_r <= !bus.sda_i;
                                end
                                scl_oe_r <= 1'b1;
                            end
                            2'd3: begin
                                if (stop_r) begin
                                    sda_oe_r <= 1'b1;
                                    state_r  <= STOP;
                                end else begin
                                    state_r <= HOLD;
                                end
                            end
                            default: state_r <= IDLE;
                        endcase
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        case (quarter_s)
                            2'd0: scl_oe_r <= 1'b0;
                            2'd1: sda_oe_r <= 1'b0;
                            2'd2: sda_oe_r <= 1'b0;
                            2'd3: begin
                                busy_r  <= 1'b0;
                                state_r <= IDLE;
                            end
                            default: state_r <= IDLE;
                        endcase
                    end
                end
                default: begin
                    scl_oe_r <= 1'b0;
                    sda_oe_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed bench for i2c_master_engine with an open-drain bus and a one-byte slave model.
module tb_i2c_master_engine;
    import i2c_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_rst;
    logic        core_en;
    logic [15:0] prescale;
    logic        busy;
    logic        rx_ack;

    i2c_master_engine_if bus ();

    i2c_master_engine #(.PRESCALE_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .core_rst_i (core_rst),
        .core_en_i  (core_en),
        .prescale_i (prescale),
        .busy_o     (busy),
        .rx_ack_o   (rx_ack),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Slave-side controls written by the stimulus.
    logic       ack_en       = 1'b1;
    logic       pending_read = 1'b0;
    logic [7:0] rd_byte      = 8'h00;
    logic       slave_scl_hold = 1'b0;

    // Bus monitor / slave state, written only by the monitor process.
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       prev_busy = 1'b0;
    logic       waiting  = 1'b0;
    logic       armed    = 1'b0;
    logic       mode_read = 1'b0;
    logic [3:0] bitpos   = 4'd0;
    logic [7:0] mon_shift = 8'h00;
    logic [7:0] last_byte = 8'h00;
    logic       ack_bit  = 1'b1;
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         busy_hi_cnt = 0;
    int         busy_fall_cnt = 0;

    logic [2:0] rd_idx;
    logic       slave_sda_pull;
    assign rd_idx         = 3'd7 - bitpos[2:0];
    assign slave_sda_pull = armed && (mode_read ? ((bitpos < 4'd8) && !rd_byte[rd_idx])
                                                : (ack_en && (bitpos == 4'd8)));
    assign bus.scl_i = !(bus.scl_oe_o || slave_scl_hold);
    assign bus.sda_i = !(bus.sda_oe_o || slave_sda_pull);

    // Decode START/STOP, bit edges and busy activity on the wired bus.
    always @(negedge clk) begin
        if (prev_scl && bus.scl_i && prev_sda && !bus.sda_i) begin
            start_cnt <= start_cnt + 1;
            waiting   <= 1'b1;
            armed     <= 1'b0;
            bitpos    <= 4'd0;
            mode_read <= pending_read;
        end else if (prev_scl && bus.scl_i && !prev_sda && bus.sda_i) begin
            stop_cnt <= stop_cnt + 1;
        end else if (prev_scl && !bus.scl_i) begin
            if (waiting) begin
                waiting <= 1'b0;
                armed   <= 1'b1;
            end else if (armed) begin
                if (bitpos == 4'd8) begin
                    armed  <= 1'b0;
                    bitpos <= 4'd0;
                end else begin
                    bitpos <= bitpos + 4'd1;
                end
            end
        end else if (!prev_scl && bus.scl_i && armed) begin
            if (bitpos < 4'd8) begin
                mon_shift <= {mon_shift[6:0], bus.sda_i};
            end else begin
                ack_bit   <= bus.sda_i;
                last_byte <= mon_shift;
            end
        end
        prev_scl  <= bus.scl_i;
        prev_sda  <= bus.sda_i;
        prev_busy <= busy;
        if (busy) busy_hi_cnt <= busy_hi_cnt + 1;
        if (prev_busy && !busy) busy_fall_cnt <= busy_fall_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic st, input logic sp, input logic rw, input logic [7:0] data);
        int n;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i.start = st;
        bus.cmd_i.stop  = sp;
        bus.cmd_i.rw    = rw;
        bus.cmd_i.data  = data;
        n = 0;
        while (!bus.cmd_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_in_time", 32'(n < 2000), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 5000), 32'd1);
    endtask

    initial begin
        int s0, p0, b0, f0, n, bad;
        logic [7:0] d0;

        rst             = 1'b1;
        core_rst        = 1'b0;
        core_en         = 1'b1;
        prescale        = 16'd4;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i       = '0;
        bus.rx_ready_i  = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        check("rst_busy",      32'(busy),            32'd0);
        check("rst_scl_oe",    32'(bus.scl_oe_o),    32'd0);
        check("rst_sda_oe",    32'(bus.sda_oe_o),    32'd0);
        check("rst_rx_valid",  32'(bus.rx_valid_o),  32'd0);
        check("rst_rx_data",   32'(bus.rx_data_o),   32'd0);
        check("rst_rx_ack",    32'(rx_ack),          32'd0);
        rst = 1'b0;
        #1;
        check("ready_follows_en", 32'(bus.cmd_ready_o), 32'd1);
        core_en = 1'b0;
        #1;
        check("ready_en_low", 32'(bus.cmd_ready_o), 32'd0);
        core_en = 1'b1;

        // Write 0xA0 with slave ACK: 44 quarters of 5 cycles.
        s0 = start_cnt; p0 = stop_cnt; b0 = busy_hi_cnt;
        ack_en = 1'b1; pending_read = 1'b0;
        send(1'b1, 1'b1, 1'b0, 8'hA0);
        wait_idle("wr_ack_idle");
        repeat (2) @(negedge clk);
        check("wr_ack_byte",   32'(last_byte),       32'hA0);
        check("wr_ack_rx_ack", 32'(rx_ack),          32'd1);
        check("wr_ack_busy",   32'(busy_hi_cnt - b0), 32'd220);
        check("wr_ack_start",  32'(start_cnt - s0),  32'd1);
        check("wr_ack_stop",   32'(stop_cnt - p0),   32'd1);
        check("wr_ack_bus_rel", 32'({bus.scl_i, bus.sda_i}), 32'd3);

        // Same write, slave NACKs.
        p0 = stop_cnt; b0 = busy_hi_cnt;
        ack_en = 1'b0;
        send(1'b1, 1'b1, 1'b0, 8'hA0);
        wait_idle("wr_nack_idle");
        repeat (2) @(negedge clk);
        check("wr_nack_rx_ack", 32'(rx_ack),           32'd0);
        check("wr_nack_stop",   32'(stop_cnt - p0),    32'd1);
        check("wr_nack_busy",   32'(busy_hi_cnt - b0), 32'd220);
        ack_en = 1'b1;

        // Read 0x5C with RX FIFO ready: one RXWAIT cycle.
        p0 = stop_cnt; b0 = busy_hi_cnt;
        pending_read = 1'b1; rd_byte = 8'h5C;
        send(1'b1, 1'b1, 1'b1, 8'h00);
        wait_idle("rd_idle");
        repeat (2) @(negedge clk);
        check("rd_data",      32'(bus.rx_data_o),    32'h5C);
        check("rd_master_nack", 32'(ack_bit),        32'd1);
        check("rd_stop",      32'(stop_cnt - p0),    32'd1);
        check("rd_busy",      32'(busy_hi_cnt - b0), 32'd221);
        check("rd_valid_clr", 32'(bus.rx_valid_o),   32'd0);

        // Read 0x3C with RX FIFO stalled for 100 cycles.
        p0 = stop_cnt; b0 = busy_hi_cnt;
        rd_byte = 8'h3C; bus.rx_ready_i = 1'b0;
        send(1'b1, 1'b1, 1'b1, 8'h00);
        n = 0;
        while (!bus.rx_valid_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 32'(n < 1000), 32'd1);
        d0 = bus.rx_data_o;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.scl_i !== 1'b0 || bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== d0) bad++;
        end
        check("stall_hold",  32'(bad), 32'd0);
        check("stall_data",  32'(d0),  32'h3C);
        bus.rx_ready_i = 1'b1;
        wait_idle("stall_idle");
        repeat (2) @(negedge clk);
        check("stall_stop",  32'(stop_cnt - p0),    32'd1);
        check("stall_busy",  32'(busy_hi_cnt - b0), 32'd321);

        // Write 0x55 without STOP, then repeated-START read of 0xC3.
        s0 = start_cnt; f0 = busy_fall_cnt;
        pending_read = 1'b0;
        send(1'b1, 1'b0, 1'b0, 8'h55);
        n = 0;
        while (!bus.cmd_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", 32'(n < 2000), 32'd1);
        core_en = 1'b0;
        #1;
        check("hold_ready",    32'(bus.cmd_ready_o), 32'd1);
        check("hold_busy",     32'(busy),            32'd1);
        check("hold_scl_low",  32'(bus.scl_i),       32'd0);
        check("hold_wr_byte",  32'(last_byte),       32'h55);
        pending_read = 1'b1; rd_byte = 8'hC3;
        send(1'b1, 1'b1, 1'b1, 8'h00);
        core_en = 1'b1;
        wait_idle("rs_idle");
        repeat (2) @(negedge clk);
        check("rs_starts",     32'(start_cnt - s0),     32'd2);
        check("rs_busy_falls", 32'(busy_fall_cnt - f0), 32'd1);
        check("rs_rd_data",    32'(bus.rx_data_o),      32'hC3);

        // Soft reset during bit 3 of a write.
        p0 = stop_cnt;
        pending_read = 1'b0;
        send(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (82) @(negedge clk);
        check("srst_pre_busy", 32'(busy), 32'd1);
        core_rst = 1'b1;
        #1;
        check("srst_ready_low", 32'(bus.cmd_ready_o), 32'd0);
        @(negedge clk);
        core_rst = 1'b0;
        #1;
        check("srst_busy",     32'(busy),            32'd0);
        check("srst_scl_oe",   32'(bus.scl_oe_o),    32'd0);
        check("srst_sda_oe",   32'(bus.sda_oe_o),    32'd0);
        check("srst_rx_valid", 32'(bus.rx_valid_o),  32'd0);
        check("srst_rx_data",  32'(bus.rx_data_o),   32'd0);
        check("srst_rx_ack",   32'(rx_ack),          32'd0);
        check("srst_ready",    32'(bus.cmd_ready_o), 32'd1);
        repeat (3) @(negedge clk);
        check("srst_no_stop",  32'(stop_cnt - p0),   32'd0);

`ifdef I2C_CLK_STRETCH_EN
        // Slave stretches SCL 50 cycles at bit 0 of a write.
        b0 = busy_hi_cnt;
        send(1'b1, 1'b1, 1'b0, 8'hA0);
        repeat (21) @(negedge clk);
        slave_scl_hold = 1'b1;
        n = 0;
        while (bus.scl_oe_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stretch_q1_seen", 32'(n < 100), 32'd1);
        repeat (50) @(negedge clk);
        slave_scl_hold = 1'b0;
        wait_idle("stretch_idle");
        repeat (2) @(negedge clk);
        check("stretch_busy", 32'(busy_hi_cnt - b0), 32'd270);
        check("stretch_byte", 32'(last_byte),        32'hA0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
